// File: rtl/exu_pipe_ctrl.sv
// exu_pipe_ctrl: pipeline stall/flush controller (load-use, mul/div, LSU wait, branch, halt) with stall perf counter
module exu_pipe_ctrl #(
    parameter int GPR_W      = 5,
    parameter int MD_TIMEOUT = 64,
    parameter int PERF_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPR_W-1:0]  id_rs1,
    input  logic [GPR_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [GPR_W-1:0]  ex1_rd,
    input  logic              ex1_mem_to_reg,
    input  logic              ex2_md_op,
    input  logic              md_done,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              ex2_branch_taken,
    input  logic              ex2_halt,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex1,
    output logic              stall_ex2,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex1,
    output logic              flush_ex2,
    output logic              flush_mem,
    output logic              halted,
    output logic              md_timeout_err,
    output logic [1:0]        state,
    output logic [PERF_W-1:0] perf_stall_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, MD_WAIT = 2'd1, MEM_WAIT = 2'd2, HALTED = 2'd3} state_t;
    localparam int CW = $clog2(MD_TIMEOUT + 1);
    state_t cur, nxt;
    logic [CW-1:0] md_cnt, md_cnt_n;
    logic err_n, mem_wait, md_wait, load_use;
    assign mem_wait = mem_req & ~mem_ready;
    assign md_wait  = ex2_md_op & ~md_done;
    assign load_use = ex1_mem_to_reg & (ex1_rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex1_rd)) | (id_use_rs2 & (id_rs2 == ex1_rd)));
    assign state  = cur;
    assign halted = (cur == HALTED);
    // A branch arriving during a wait is not dropped: EX2 stays stalled, so it is seen again on release.
    always_comb begin
        {stall_if, stall_id, stall_ex1, stall_ex2, stall_mem} = '0;
        {flush_id, flush_ex1, flush_ex2, flush_mem} = '0;
        nxt      = cur;
        md_cnt_n = md_cnt;
        err_n    = md_timeout_err;
        if (!rst) begin
            if (cur == HALTED) begin
                {stall_if, stall_id, stall_ex1, stall_ex2, stall_mem} = '1;
            end else if (mem_wait) begin
                {stall_if, stall_id, stall_ex1, stall_ex2, stall_mem} = '1;
                nxt = MEM_WAIT;
            end else if (md_wait) begin
                {stall_if, stall_id, stall_ex1, stall_ex2} = '1;
                flush_mem = 1'b1;
                md_cnt_n  = md_cnt + CW'(cur == MD_WAIT);
                err_n     = md_timeout_err | (md_cnt_n == CW'(MD_TIMEOUT));
                nxt       = (md_cnt_n == CW'(MD_TIMEOUT)) ? HALTED : MD_WAIT;
            end else begin
                md_cnt_n  = '0;
                nxt       = ex2_halt ? HALTED : RUN;
                flush_mem = ex2_halt;
                {flush_id, flush_ex2} = {2{~ex2_halt & ex2_branch_taken}};
                {stall_if, stall_id}  = {2{~ex2_halt & ~ex2_branch_taken & load_use}};
                flush_ex1 = ~ex2_halt & (ex2_branch_taken | load_use);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cur            <= RUN;
            md_cnt         <= '0;
            md_timeout_err <= 1'b0;
            perf_stall_cnt <= '0;
        end else begin
            cur            <= nxt;
            md_cnt         <= md_cnt_n;
            md_timeout_err <= err_n;
            if (stall_if && cur != HALTED && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_exu_pipe_ctrl.sv
// tb_exu_pipe_ctrl: directed stimulus checked every cycle against a behavioural model of exu_pipe_ctrl
module tb_exu_pipe_ctrl;
    localparam int TO = 8;
    localparam int PW = 4;
    logic clk = 0, rst = 1;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex1_rd = 0;
    logic id_use_rs1 = 0, id_use_rs2 = 0, ex1_mem_to_reg = 0, ex2_md_op = 0, md_done = 0;
    logic mem_req = 0, mem_ready = 0, ex2_branch_taken = 0, ex2_halt = 0;
    logic stall_if, stall_id, stall_ex1, stall_ex2, stall_mem;
    logic flush_id, flush_ex1, flush_ex2, flush_mem, halted, md_timeout_err;
    logic [1:0] state;
    logic [PW-1:0] perf_stall_cnt;
    int passed = 0, total = 0;

    exu_pipe_ctrl #(.GPR_W(5), .MD_TIMEOUT(TO), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex1_rd(ex1_rd), .ex1_mem_to_reg(ex1_mem_to_reg),
        .ex2_md_op(ex2_md_op), .md_done(md_done), .mem_req(mem_req), .mem_ready(mem_ready),
        .ex2_branch_taken(ex2_branch_taken), .ex2_halt(ex2_halt), .stall_if(stall_if),
        .stall_id(stall_id), .stall_ex1(stall_ex1), .stall_ex2(stall_ex2), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex1(flush_ex1), .flush_ex2(flush_ex2), .flush_mem(flush_mem),
        .halted(halted), .md_timeout_err(md_timeout_err), .state(state),
        .perf_stall_cnt(perf_stall_cnt));

    always #5 clk = ~clk;

    // model state: frozen flag, sticky error, consecutive md-wait cycles, stall count, reported state
    int m_frozen = 0, m_err = 0, m_wait = 0, m_perf = 0, m_state = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // expected {stall if,id,ex1,ex2,mem, flush id,ex1,ex2,mem}
    function automatic logic [8:0] expect_vec();
        bit lu;
        lu = ex1_mem_to_reg && ex1_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex1_rd) || (id_use_rs2 && id_rs2 == ex1_rd));
        if (rst) return 9'b0;
        if (m_frozen || (mem_req && !mem_ready)) return 9'b11111_0000;
        if (ex2_md_op && !md_done) return 9'b11110_0001;
        if (ex2_halt) return 9'b00000_0001;
        if (ex2_branch_taken) return 9'b00000_1110;
        if (lu) return 9'b11000_0100;
        return 9'b0;
    endfunction

    always @(posedge clk) begin
        logic [8:0] v;
        v = expect_vec();
        if (rst) begin
            m_frozen = 0; m_err = 0; m_wait = 0; m_perf = 0; m_state = 0;
        end else begin
            if (v[8] && !m_frozen && m_perf < 2**PW - 1) m_perf++;
            if (m_frozen) begin
            end else if (mem_req && !mem_ready) m_state = 2;
            else if (ex2_md_op && !md_done) begin
                if (m_state == 1) m_wait++;
                if (m_wait == TO) begin m_err = 1; m_frozen = 1; m_state = 3; end
                else m_state = 1;
            end else begin
                m_wait = 0;
                if (ex2_halt) begin m_frozen = 1; m_state = 3; end
                else m_state = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("ctl_vec", int'({stall_if, stall_id, stall_ex1, stall_ex2, stall_mem,
                             flush_id, flush_ex1, flush_ex2, flush_mem}), int'(expect_vec()));
        chk("state", int'(state), m_state);
        chk("halted", int'(halted), m_frozen);
        chk("md_err", int'(md_timeout_err), m_err);
        chk("perf", int'(perf_stall_cnt), m_perf);
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic clr();
        {id_rs1, id_rs2, ex1_rd} = '0;
        {id_use_rs1, id_use_rs2, ex1_mem_to_reg, ex2_md_op, md_done} = '0;
        {mem_req, mem_ready, ex2_branch_taken, ex2_halt} = '0;
    endtask
    task automatic do_reset();
        clr(); rst = 1; step(); rst = 0;
    endtask

    initial begin
        step(2); rst = 0;
        chk("lit_reset_state", int'(state), 0);
        chk("lit_reset_perf", int'(perf_stall_cnt), 0);
        // load-use on rs2
        ex1_mem_to_reg = 1; ex1_rd = 5; id_rs2 = 5; id_use_rs2 = 1; #1;
        chk("lit_lu_vec", int'({stall_if, stall_id, flush_ex1, stall_ex1}), 4'b1110);
        step(); clr(); step();
        ex1_mem_to_reg = 1; ex1_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #1;
        chk("lit_lu_x0", int'(stall_if), 0);
        step(); clr();
        // mul/div done at cycle 4
        do_reset();
        ex2_md_op = 1; step(3); md_done = 1; #1;
        chk("lit_md_release", int'(stall_ex2), 0);
        step(); clr(); step();
        chk("lit_md_perf", int'(perf_stall_cnt), 3);
        // mem wait with pending branch
        do_reset();
        mem_req = 1; ex2_branch_taken = 1; step(2);
        mem_ready = 1; #1;
        chk("lit_mem_brflush", int'({flush_id, flush_ex1, flush_ex2, stall_if}), 4'b1110);
        step(); clr(); step();
        // branch plus load-use
        ex2_branch_taken = 1; ex1_mem_to_reg = 1; ex1_rd = 7; id_rs1 = 7; id_use_rs1 = 1; step(); clr();
        // halt then reset
        ex2_halt = 1; step(); clr(); step(3);
        chk("lit_halted", int'(halted), 1);
        mem_ready = 1; ex2_branch_taken = 1; step(); clr();
        do_reset();
        chk("lit_halt_rst", int'(state), 0);
        // mul/div timeout
        ex2_md_op = 1; step(TO + 1);
        chk("lit_to_err", int'(md_timeout_err), 1);
        chk("lit_to_state", int'(state), 3);
        md_done = 1; step(2); clr(); step();
        do_reset();
        // mem wait interrupting a mul/div wait, then perf saturation
        ex2_md_op = 1; step(3); mem_req = 1; step(2); mem_req = 0; step(2); md_done = 1; step(); clr();
        do_reset();
        mem_req = 1; step(20);
        chk("lit_perf_sat", int'(perf_stall_cnt), 15);
        clr(); step(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
